// File: rtl/layer_bus_serializer.sv
// ============================================================================
//  Module   : layer_bus_serializer
//  Purpose  : Ping-pong buffered serializer from a layer's parallel result bus
//             to a one-word-per-cycle valid/ready stream, lowest word first.
//             Optional macro LAYER_SERIALIZER_RELU_EN clamps negative words.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_bus_serializer #(
    parameter int dataWidth = 16,
    parameter int neuron_no = 20,
    parameter int frac_bits = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           done_in,
    input  logic [dataWidth*neuron_no-1:0] data_in,
    output logic [dataWidth-1:0]           data_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic                           last_out,
    output logic                           freeze_r,
    output logic                           done_out,
    output logic                           overrun,
    input  logic                           overrun_clr
);

    localparam int                   c_IDX_W    = $clog2(neuron_no);
    localparam int                   c_FRAME_W  = dataWidth * neuron_no;
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(neuron_no - 1);

    if (neuron_no < 2 || frac_bits >= dataWidth) begin : g_param_check
        $error("layer_bus_serializer: illegal neuron_no or frac_bits");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_FRAME_W-1:0] bank_q [2];
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic [dataWidth-1:0] data_out_q, data_out_d;
    logic                 last_out_q, last_out_d;
    logic                 done_out_q, done_out_d;
    logic                 overrun_q, overrun_d;

    logic                 w_xfer;
    logic                 w_release;
    logic                 w_capture;
    logic                 w_drop;
    logic [c_FRAME_W-1:0] w_rd_frame;
    logic [dataWidth-1:0] w_word;
    logic [dataWidth-1:0] w_word_out;

    assign w_xfer    = (state_q == ST_STREAM) && ready_in;
    assign w_release = w_xfer && (idx_q == c_LAST_IDX);
    // A bank released on this edge is free for a same-cycle capture.
    assign w_capture = done_in && (!full_q[wr_bank_q] || (w_release && (rd_bank_q == wr_bank_q)));
    assign w_drop    = done_in && !w_capture;

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        idx_d      = idx_q;
        done_out_d = 1'b0;
        overrun_d  = overrun_q;

        if (w_release) full_d[rd_bank_q] = 1'b0;
        if (w_capture) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end

        if (w_drop)           overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_xfer) begin
                    if (idx_q != c_LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        rd_bank_d  = ~rd_bank_q;
                        idx_d      = '0;
                        done_out_d = 1'b1;
                        if (!full_q[~rd_bank_q]) state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output word is looked up from the next-cycle pointer so data_out is a register.
    always_comb begin
        w_rd_frame = bank_q[rd_bank_d];
        w_word     = '0;
        for (int k = 0; k < neuron_no; k++) begin
            if (idx_d == c_IDX_W'(k)) w_word = w_rd_frame[k*dataWidth +: dataWidth];
        end
    end

`ifdef LAYER_SERIALIZER_RELU_EN
    assign w_word_out = w_word[dataWidth-1] ? '0 : w_word;
`else
    assign w_word_out = w_word;
`endif

    always_comb begin
        data_out_d = (state_d == ST_STREAM) ? w_word_out : '0;
        last_out_d = (state_d == ST_STREAM) && (idx_d == c_LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            idx_q      <= '0;
            data_out_q <= '0;
            last_out_q <= 1'b0;
            done_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
            last_out_q <= last_out_d;
            done_out_q <= done_out_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) bank_q[wr_bank_q] <= data_in;
    end

    assign valid_out = (state_q == ST_STREAM);
    assign data_out  = data_out_q;
    assign last_out  = last_out_q;
    assign done_out  = done_out_q;
    assign overrun   = overrun_q;
    assign freeze_r  = !(valid_out && ready_in);

endmodule

`default_nettype wire

// File: tb/tb_layer_bus_serializer.sv
// ============================================================================
//  Module   : tb_layer_bus_serializer
//  Purpose  : Scoreboard bench for layer_bus_serializer (4 words x 16 bits).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_bus_serializer;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           done_in;
    logic [W*N-1:0] data_in;
    logic [W-1:0]   data_out;
    logic           valid_out;
    logic           ready_in;
    logic           last_out;
    logic           freeze_r;
    logic           done_out;
    logic           overrun;
    logic           overrun_clr;

    layer_bus_serializer #(.dataWidth(W), .neuron_no(N), .frac_bits(11)) dut (
        .clk(clk), .rst_n(rst_n), .done_in(done_in), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .last_out(last_out), .freeze_r(freeze_r), .done_out(done_out),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] w;
        bit           last;
        int           cap;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_pop;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   ov_model = 1'b0;
    bit   ov_next  = 1'b0;
    bit   done_exp = 1'b0;
    bit   expect_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [W-1:0] model_word(input logic [W-1:0] x);
`ifdef LAYER_SERIALIZER_RELU_EN
        return x[W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Drive one cycle starting at a falling edge; decide acceptance from the frame count.
    task automatic tick(input bit d, input logic [W*N-1:0] frm, input bit rdy, input bit clr);
        bit drop;
        bit rel;
        int held;
        ready_in    = rdy;
        overrun_clr = clr;
        done_in     = d;
        data_in     = frm;
        drop        = 1'b0;
        if (d) begin
            held = 0;
            foreach (exp_q[i]) if (exp_q[i].last) held++;
            rel = valid_out && rdy && (exp_q.size() > 0) && exp_q[0].last;
            if (held < 2 || rel) begin
                for (int k = 0; k < N; k++)
                    exp_q.push_back('{model_word(frm[k*W +: W]), (k == N-1), cyc});
            end else begin
                drop = 1'b1;
            end
        end
        ov_next = drop ? 1'b1 : (clr ? 1'b0 : ov_model);
        @(negedge clk);
        done_in     = 1'b0;
        overrun_clr = 1'b0;
    endtask

    function automatic logic [W*N-1:0] rnd_frame();
        return {$urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            check("overrun", overrun, ov_model);
            ov_model = ov_next;
            check("done_out", done_out, done_exp);
            done_exp = 1'b0;
            check("freeze_r", freeze_r, ready_in ? !valid_out : 1'b1);
            if (expect_valid) begin
                check("no_bubble", valid_out, 1'b1);
                expect_valid = 1'b0;
            end
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", valid_out, 1'b0);
                end else begin
                    check("data_out", data_out, exp_q[0].w);
                    check("last_out", last_out, exp_q[0].last);
                    if (ready_in) begin
                        e_pop = exp_q.pop_front();
                        if (e_pop.last) begin
                            done_exp = 1'b1;
                            if (exp_q.size() > 0 && exp_q[0].cap < cyc) expect_valid = 1'b1;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", valid_out, 1'b0);
        check("rst_freeze", freeze_r, 1'b1);
        check("rst_last", last_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        exp_q.delete();
        ov_model = 1'b0;
        ov_next = 1'b0;
        done_exp = 1'b0;
        expect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hit;
        rst_n = 1'b0; done_in = 1'b0; data_in = '0; ready_in = 1'b0; overrun_clr = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_data", data_out, 16'h0);

        // Single frame: latency and in-order output
        tick(1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
        check("latency_edgeN", valid_out, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        check("latency_valid", valid_out, 1'b1);
        check("latency_word0", data_out, 16'h0001);
        repeat (6) tick(1'b0, '0, 1'b1, 1'b0);

        // Backpressure 1,0,0,1
        tick(1'b1, 64'h00A4_00A3_00A2_00A1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);

        // Ping-pong: second frame mid-drain
        tick(1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b1, 64'h0014_0013_0012_0011, 1'b1, 1'b0);
        repeat (10) tick(1'b0, '0, 1'b1, 1'b0);

        // Overrun: three frames while stalled
        tick(1'b1, 64'h0104_0103_0102_0101, 1'b0, 1'b0);
        tick(1'b1, 64'h0204_0203_0202_0201, 1'b0, 1'b0);
        tick(1'b1, 64'h0304_0303_0302_0301, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        check("overrun_set", overrun, 1'b1);
        repeat (12) tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b0);
        check("overrun_clr", overrun, 1'b0);

        // Simultaneous release of one bank and capture, other bank full
        tick(1'b1, 64'h0414_0413_0412_0411, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, 64'h0424_0423_0422_0421, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            if (valid_out && exp_q.size() > 0 && exp_q[0].last && exp_q[0].w == 16'h0414) begin
                tick(1'b1, 64'h0434_0433_0432_0431, 1'b1, 1'b0);
                hit = 1;
            end else begin
                tick(1'b0, '0, 1'b1, 1'b0);
            end
        end
        check("simul_reached", hit, 1);
        repeat (12) tick(1'b0, '0, 1'b1, 1'b0);
        check("simul_no_overrun", overrun, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            tick(($urandom_range(0, 3) == 0), rnd_frame(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1'b0, '0, 1'b1, 1'b0);
        check("drain_empty", exp_q.size(), 0);
        repeat (2) tick(1'b0, '0, 1'b1, 1'b0);

        // Reset in the middle of a frame
        tick(1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0);
        check("pre_reset_valid", valid_out, 1'b1);
        do_reset();
        tick(1'b0, '0, 1'b1, 1'b0);
        check("post_reset_idle", valid_out, 1'b0);
        tick(1'b1, 64'h0004_0003_0002_8003, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        check("post_reset_word0", data_out, model_word(16'h8003));
        repeat (8) tick(1'b0, '0, 1'b1, 1'b0);
        check("final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/layer_bus_serializer.md
# layer_bus_serializer

Ping-pong buffered serializer between a neuron layer's parallel output bus and the next layer's one-word-per-cycle input. It captures a full layer result on a `done_in` pulse into one of two banks and streams the words out, lowest neuron first, under a valid/ready handshake. It drives the downstream `freeze` control and a completion pulse. This block is the parametrised successor to the store/select pair between hidden layers. Because of the second bank, the upstream layer can deliver the next frame while the current one is still draining.

## Interface
Parameters:
- `dataWidth`, 16: width of one neuron word (signed, Q-format, `frac_bits` fractional).
- `neuron_no`, 20: words per layer frame; legal range 2..1024.
- `frac_bits`, 11: fractional bits. Informational only; no arithmetic depends on it.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `done_in`  in  1: one-cycle pulse; `data_in` is valid in the same cycle.
- `data_in`  in  `dataWidth*neuron_no`: layer result; word k is `data_in[k*dataWidth +: dataWidth]`.
- `data_out`  out  `dataWidth`: current streamed word.
- `valid_out`  out  1: `data_out` holds a valid word.
- `ready_in`  in  1: downstream accepts the word this cycle.
- `last_out`  out  1: the current word is word `neuron_no-1`.
- `freeze_r`  out  1: downstream MAC hold.
- `done_out`  out  1: one-cycle pulse after the last word of a frame is accepted.
- `overrun`  out  1: sticky flag; a frame was dropped.
- `overrun_clr`  in  1: synchronous clear for `overrun`.

## Operation
- Storage: two banks, each `dataWidth*neuron_no` bits. Per-bank `full` flag. `wr_bank` and `rd_bank` pointers, `idx` counter of width `$clog2(neuron_no)`.
- Capture: when `done_in=1` and `bank[wr_bank]` is not full:
  - copy `data_in` into that bank;
  - set its `full` flag;
  - toggle `wr_bank`.
- If `done_in=1` and both banks are full, drop the frame, set `overrun=1`, and leave the stored data unchanged.
- FSM has two states:
  - IDLE: `valid_out=0`. Go to STREAM when `full[rd_bank]` is set.
  - STREAM: `valid_out=1`, `data_out` = word `idx` of `rd_bank`. On `valid_out && ready_in`:
    - if `idx < neuron_no-1`, increment `idx`;
    - otherwise clear `full[rd_bank]`, toggle `rd_bank`, reset `idx` to 0, pulse `done_out`, then stay in STREAM if the other bank is full, else go to IDLE.
- `last_out = valid_out && idx == neuron_no-1`.
- `freeze_r = !(valid_out && ready_in)`. The downstream layer accumulates only on transfer cycles.
- Simultaneous last-word acceptance and `done_in` with the other bank full: the bank released in that cycle counts as free. The capture is accepted and there is no overrun.
- `overrun_clr` and an overrun event in the same cycle: `overrun` stays 1 (set wins).
- Reset value of every register:
  - `valid_out=0`, `data_out=0`, `last_out=0`, `freeze_r=1`;
  - `done_out=0`, `overrun=0`;
  - both `full` flags 0, pointers 0, `idx=0`, FSM in IDLE.
- Reset asserted mid-frame discards all stored frames. There are no partial outputs after release.
- Bank contents are not required to be reset.

## Timing
- Capture latency: `done_in` at edge N with the FSM in IDLE gives `valid_out=1` with word 0 after edge N+1 (one cycle).
- Throughput: one word per cycle while `ready_in=1`. A frame drains in `neuron_no` transfer cycles.
- Back-to-back frames: with the other bank full, word 0 of the next frame is presented in the cycle right after the last-word acceptance. There is no bubble.
- `done_out`: high for exactly the one cycle after the last-word acceptance edge.
- `data_out` and `last_out` are stable while `valid_out=1 && ready_in=0`.
- `freeze_r` is combinational from `ready_in`. All other outputs are registered.

## Configuration
- `LAYER_SERIALIZER_RELU_EN`:
  - Defined: `data_out` is ReLU-clamped at the output mux. Negative words (MSB=1) are replaced by 0 and non-negative words pass unchanged. No added latency.
  - Undefined: words pass through unmodified.

## Test plan
- Single frame, `neuron_no=4`, words 0x0001..0x0004, `ready_in` held 1 → `valid_out` rises 1 cycle after `done_in`. Outputs are 1,2,3,4 on consecutive cycles, `last_out` is high on the 4th word, and `done_out` pulses 1 cycle later.
- Backpressure: `ready_in` toggling 1,0,0,1,… → every word appears once, in order, and is held stable while stalled. `freeze_r=1` on every cycle where `ready_in=0`.
- Ping-pong: second `done_in` (0x0011..0x0014) arrives mid-drain of frame 1 → frame 2 word 0 appears in the cycle right after frame 1's last acceptance, with no idle cycle.
- Overrun: three `done_in` pulses while `ready_in=0` → third frame dropped and `overrun=1`. Frames 1 and 2 drain intact. `overrun_clr` returns `overrun` to 0.
- Simultaneous release and capture: `done_in` in the same cycle as the last-word acceptance, other bank full → capture accepted, `overrun` stays 0, and all three frames are output in order.
- Reset mid-frame: `rst_n` low after word 2 → `valid_out=0` and `freeze_r=1` immediately. After release, a new frame streams from word 0; with `LAYER_SERIALIZER_RELU_EN` defined, word 0x8003 is output as 0x0000.
